// File: rtl/esfa_test_pkg.sv
// esfa_test_pkg: instruction word layout, pass-code default and sequencer state encoding
package esfa_test_pkg;
  localparam int INSTR_W = 56;
  localparam int FLD_W = 8;
  localparam int WILL_WRITE_BIT = 0;
  localparam int NEW_INDEX_LSB = 8;
  localparam int NEW_VALUE_LSB = 16;
  localparam int METADATA_LSB = 24;
  localparam int IS_METADATA_BIT = 32;
  localparam int SELECTOR_LSB = 40;
  localparam int ASSERT_BIT = 48;
  localparam logic [7:0] PASS_CODE_DEF = 8'h3E;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;
endpackage

// File: rtl/esfa_pipe_delay.sv
// esfa_pipe_delay: WIDTH x DEPTH delay line with per-stage valid and synchronous flush
module esfa_pipe_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);
  logic [DEPTH-1:0]            r_v;
  logic [DEPTH-1:0][WIDTH-1:0] r_d;
  // advance every stage by one each cycle; flush empties all stages including the incoming one
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_v <= '0;
      r_d <= '0;
    end else begin
      r_v[0] <= i_valid & ~i_flush;
      r_d[0] <= i_data;
      for (int k = 1; k < DEPTH; k++) begin
        r_v[k] <= r_v[k-1] & ~i_flush;
        r_d[k] <= r_d[k-1];
      end
    end
  assign o_valid = r_v[DEPTH-1];
  assign o_data = r_d[DEPTH-1];
endmodule

// File: rtl/esfa_test_sequencer.sv
// esfa_test_sequencer: streams a ROM test program into the DUT and checks asserted results
module esfa_test_sequencer
  import esfa_test_pkg::*;
#(
  parameter int         ADDR_W       = 6,
  parameter int         NUM_INSTR    = 1,
  parameter int         ROM_LAT      = 1,
  parameter int         DUT_LAT      = 1,
  parameter logic [7:0] PASS_CODE    = PASS_CODE_DEF,
  parameter bit         STOP_ON_FAIL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [INSTR_W-1:0] i_rom_data,
  output logic               o_dut_valid,
  output logic               o_dut_will_write,
  output logic [7:0]         o_dut_new_index,
  output logic [7:0]         o_dut_new_value,
  output logic [7:0]         o_dut_metadata,
  output logic               o_dut_is_metadata,
  output logic [7:0]         o_dut_selector,
  input  logic               i_dut_result_bool,
  input  logic [7:0]         i_dut_result_value,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [7:0]         o_result_code,
  output logic [ADDR_W:0]    o_fail_count
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_INSTR == 0 ? 0 : NUM_INSTR - 1);
  localparam int EW = ADDR_W + 2 + FLD_W;
  if (ADDR_W > 8 || NUM_INSTR > 2 ** ADDR_W || ROM_LAT < 1 || DUT_LAT < 1) begin : g_bad_cfg
    $error("esfa_test_sequencer: illegal parameter combination");
  end
  state_t            r_st, w_nx;
  logic [ADDR_W-1:0] r_addr, w_ridx, r_didx, w_cidx;
  logic [INSTR_W-1:0] r_word;
  logic [EW-1:0]     w_cdata;
  logic              r_dv, w_rv, w_cv, w_casr, w_cb, w_issue, w_go, w_fail, w_kill, w_enter, r_pass;
  logic [7:0]        w_cval, r_rc, w_rc;
  logic [ADDR_W:0]   r_fc, w_fc;
  logic              w_unused;
  assign w_go = (r_st == ST_IDLE || r_st == ST_DONE) && i_start;
  assign {w_casr, w_cb, w_cval, w_cidx} = w_cdata;
  assign w_fail = w_cv && w_casr && (i_dut_result_bool != w_cb || i_dut_result_value != w_cval);
  assign w_kill = STOP_ON_FAIL && w_fail;
  assign w_enter = w_nx == ST_DONE && (r_st != ST_DONE || w_go);
  assign w_fc = w_go ? '0 : (w_fail && !(&r_fc)) ? r_fc + 1'b1 : r_fc;
  assign w_rc = w_go ? 8'h00 : (w_fail && r_fc == '0) ? 8'(w_cidx) : r_rc;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_st <= ST_IDLE;
    else r_st <= w_nx;
  // next state and issue strobe; index 0 is already on rom_addr when start is accepted
  always_comb begin
    w_nx = r_st;
    w_issue = 1'b0;
    case (r_st)
      ST_IDLE, ST_DONE:
        if (i_start) begin
          w_issue = NUM_INSTR != 0;
          w_nx = NUM_INSTR == 0 ? ST_DONE : LAST == '0 ? ST_DRAIN : ST_RUN;
        end
      ST_RUN: begin
        w_issue = !w_kill;
        w_nx = w_kill ? ST_DONE : r_addr == LAST ? ST_DRAIN : ST_RUN;
      end
      default: w_nx = (w_kill || (w_cv && w_cidx == LAST)) ? ST_DONE : ST_DRAIN;
    endcase
  end
  // address counter parks at 0 whenever no run is issuing
  always_ff @(posedge clk or posedge rst)
    if (rst) r_addr <= '0;
    else if (w_kill) r_addr <= '0;
    else if (w_issue) r_addr <= r_addr == LAST ? '0 : r_addr + 1'b1;
  esfa_pipe_delay #(.WIDTH(ADDR_W), .DEPTH(ROM_LAT)) u_rom_pipe (
    .clk(clk), .rst(rst), .i_flush(w_kill), .i_valid(w_issue), .i_data(r_addr),
    .o_valid(w_rv), .o_data(w_ridx)
  );
  // register the ROM word onto the DUT-facing fields
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_dv <= 1'b0;
      r_word <= '0;
      r_didx <= '0;
    end else begin
      r_dv <= w_rv & ~w_kill;
      if (w_rv) begin
        r_word <= i_rom_data;
        r_didx <= w_ridx;
      end
    end
  esfa_pipe_delay #(.WIDTH(EW), .DEPTH(DUT_LAT)) u_exp_pipe (
    .clk(clk), .rst(rst), .i_flush(w_kill), .i_valid(r_dv),
    .i_data({r_word[ASSERT_BIT], r_word[IS_METADATA_BIT], r_word[METADATA_LSB +: FLD_W], r_didx}),
    .o_valid(w_cv), .o_data(w_cdata)
  );
  // error count, first failing index, and the final verdict on entry to DONE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_fc <= '0;
      r_rc <= 8'h00;
      r_pass <= 1'b0;
    end else begin
      r_fc <= w_fc;
      r_rc <= (w_enter && w_fc == '0) ? PASS_CODE : w_rc;
      r_pass <= w_enter ? w_fc == '0 : r_pass & ~w_go;
    end
  assign w_unused = ^{r_word[7:1], r_word[39:33], r_word[55:49]};
  assign o_rom_addr = r_addr;
  assign o_dut_valid = r_dv;
  assign o_dut_will_write = r_word[WILL_WRITE_BIT];
  assign o_dut_new_index = r_word[NEW_INDEX_LSB +: FLD_W];
  assign o_dut_new_value = r_word[NEW_VALUE_LSB +: FLD_W];
  assign o_dut_metadata = r_word[METADATA_LSB +: FLD_W];
  assign o_dut_is_metadata = r_word[IS_METADATA_BIT];
  assign o_dut_selector = r_word[SELECTOR_LSB +: FLD_W];
  assign o_busy = r_st == ST_RUN || r_st == ST_DRAIN;
  assign o_done = r_st == ST_DONE;
  assign o_pass = r_pass;
  assign o_result_code = r_rc;
  assign o_fail_count = r_fc;
endmodule

// File: tb/tb_esfa_test_sequencer.sv
// tb_esfa_test_sequencer: five configurations checked against a program-level result model
module tb_esfa_test_sequencer;
  localparam int NI = 5;
  localparam int PN [NI] = '{8, 8, 2, 4, 0};
  localparam int PR [NI] = '{1, 1, 2, 1, 1};
  localparam int PD [NI] = '{1, 1, 3, 1, 1};
  localparam bit PS [NI] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start [NI];
  logic [5:0] addr [NI];
  logic [55:0] rdata [NI];
  logic dv [NI], dww [NI], dism [NI], rbool [NI], busy [NI], done [NI], pass [NI];
  logic [7:0] dni [NI], dnv [NI], dmeta [NI], dsel [NI], rval [NI], rc [NI];
  logic [6:0] fc [NI];
  logic [55:0] mem [NI][8];
  logic [1:0] badk [NI][8];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NI; g++) begin : g_i
    logic [5:0] ap [PR[g]];
    logic [7:0] pv [PD[g]];
    logic pb [PD[g]];
    esfa_test_sequencer #(
      .ADDR_W(6), .NUM_INSTR(PN[g]), .ROM_LAT(PR[g]), .DUT_LAT(PD[g]),
      .PASS_CODE(8'h3E), .STOP_ON_FAIL(PS[g])
    ) u_dut (
      .clk(clk), .rst(rst), .i_start(start[g]), .o_rom_addr(addr[g]), .i_rom_data(rdata[g]),
      .o_dut_valid(dv[g]), .o_dut_will_write(dww[g]), .o_dut_new_index(dni[g]),
      .o_dut_new_value(dnv[g]), .o_dut_metadata(dmeta[g]), .o_dut_is_metadata(dism[g]),
      .o_dut_selector(dsel[g]), .i_dut_result_bool(rbool[g]), .i_dut_result_value(rval[g]),
      .o_busy(busy[g]), .o_done(done[g]), .o_pass(pass[g]), .o_result_code(rc[g]),
      .o_fail_count(fc[g])
    );
    // ROM with PR cycles of read latency, and a DUT answering with PD cycles of latency,
    // corrupting bool and/or value for the instructions marked bad
    always @(posedge clk) begin
      ap[0] <= addr[g];
      pv[0] <= dmeta[g] ^ ((dv[g] && badk[g][dni[g][2:0]][1]) ? 8'h5A : 8'h00);
      pb[0] <= dism[g] ^ (dv[g] && badk[g][dni[g][2:0]][0]);
      for (int k = 1; k < PR[g]; k++) ap[k] <= ap[k-1];
      for (int k = 1; k < PD[g]; k++) begin
        pv[k] <= pv[k-1];
        pb[k] <= pb[k-1];
      end
    end
    assign rdata[g] = mem[g][ap[PR[g]-1][2:0]];
    assign rval[g] = pv[PD[g]-1];
    assign rbool[g] = pb[PD[g]-1];
  end
  function automatic logic [33:0] fields(input logic [55:0] w);
    return {w[0], w[15:8], w[23:16], w[31:24], w[32], w[47:40]};
  endfunction
  task automatic fill(input int g, input bit rnd);
    for (int i = 0; i < 8; i++) begin
      mem[g][i] = 56'({$urandom(), $urandom()});
      mem[g][i][15:8] = 8'(i);
      mem[g][i][48] = rnd ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      badk[g][i] = (rnd && $urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    end
  endtask
  task automatic model(input int g, output int lat, output int nv, output logic [7:0] code, output int cnt);
    int first;
    first = -1;
    cnt = 0;
    for (int i = 0; i < PN[g]; i++)
      if (mem[g][i][48] && badk[g][i] != 2'b00) begin
        if (first < 0) first = i;
        cnt++;
      end
    if (PS[g] && first >= 0) begin
      lat = first + PR[g] + PD[g] + 2;
      cnt = 1;
      nv = (first + PD[g] + 1 < PN[g]) ? first + PD[g] + 1 : PN[g];
    end else begin
      lat = PN[g] == 0 ? 1 : PN[g] + PR[g] + PD[g] + 1;
      nv = PN[g];
    end
    code = first < 0 ? 8'h3E : 8'(first);
  endtask
  task automatic run(input int g, input int again, output int lat, output int nv);
    lat = -1;
    nv = 0;
    start[g] = 1'b1;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      @(negedge clk);
      start[g] = (c == again);
      if (dv[g]) begin
        tests++;
        if ({dww[g], dni[g], dnv[g], dmeta[g], dism[g], dsel[g]} !== fields(mem[g][nv % 8])) begin
          fails++;
          $display("FAIL dut_fields inst %0d slot %0d: got %h want %h", g, nv,
                   {dww[g], dni[g], dnv[g], dmeta[g], dism[g], dsel[g]}, fields(mem[g][nv % 8]));
        end
        nv++;
      end
      tests++;
      if (addr[g] > 6'(PN[g] == 0 ? 0 : PN[g] - 1)) begin
        fails++;
        $display("FAIL rom_addr_range inst %0d: got %0d limit %0d", g, addr[g], PN[g] - 1);
      end
      if (done[g]) lat = c;
    end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      tests++;
      if ({addr[g], dv[g], busy[g], done[g], pass[g], rc[g], fc[g]} !== 25'd0) begin
        fails++;
        $display("FAIL reset_state inst %0d: got %h want 0", g,
                 {addr[g], dv[g], busy[g], done[g], pass[g], rc[g], fc[g]});
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_clean;
    int lat, nv;
    fill(3, 1'b0);
    run(3, -1, lat, nv);
    tests++;
    if (lat !== 7) begin fails++; $display("FAIL clean_latency: got %0d want 7", lat); end
    tests++;
    if ({pass[3], rc[3], fc[3], busy[3]} !== {1'b1, 8'h3E, 7'd0, 1'b0}) begin
      fails++;
      $display("FAIL clean_result: got pass=%b code=%h fails=%0d busy=%b want 1 3e 0 0", pass[3], rc[3], fc[3], busy[3]);
    end
  endtask
  task automatic test_stop_on_fail;
    int lat, nv;
    fill(0, 1'b0);
    badk[0][5] = 2'b10;
    badk[0][6] = 2'b01;
    run(0, -1, lat, nv);
    tests++;
    if ({pass[0], rc[0], fc[0]} !== {1'b0, 8'h05, 7'd1}) begin
      fails++;
      $display("FAIL stop_result: got pass=%b code=%h fails=%0d want 0 05 1", pass[0], rc[0], fc[0]);
    end
    tests++;
    if (nv !== 7) begin fails++; $display("FAIL stop_squash: got %0d dut_valid beats want 7", nv); end
    tests++;
    if (lat !== 9) begin fails++; $display("FAIL stop_latency: got %0d want 9", lat); end
  endtask
  task automatic test_continue;
    int lat, nv;
    fill(1, 1'b0);
    badk[1][2] = 2'b01;
    badk[1][6] = 2'b11;
    run(1, -1, lat, nv);
    tests++;
    if ({pass[1], rc[1], fc[1]} !== {1'b0, 8'h02, 7'd2}) begin
      fails++;
      $display("FAIL continue_result: got pass=%b code=%h fails=%0d want 0 02 2", pass[1], rc[1], fc[1]);
    end
    tests++;
    if (lat !== 11 || nv !== 8) begin
      fails++;
      $display("FAIL continue_full_run: got lat=%0d beats=%0d want 11 8", lat, nv);
    end
  endtask
  task automatic test_unasserted;
    int lat, nv;
    fill(1, 1'b0);
    mem[1][3][48] = 1'b0;
    badk[1][3] = 2'b11;
    run(1, -1, lat, nv);
    tests++;
    if ({pass[1], rc[1], fc[1]} !== {1'b1, 8'h3E, 7'd0}) begin
      fails++;
      $display("FAIL unasserted_result: got pass=%b code=%h fails=%0d want 1 3e 0", pass[1], rc[1], fc[1]);
    end
  endtask
  task automatic test_latency;
    int lat, nv;
    fill(2, 1'b0);
    badk[2][1] = 2'b10;
    run(2, -1, lat, nv);
    tests++;
    if ({pass[2], rc[2], fc[2]} !== {1'b0, 8'h01, 7'd1}) begin
      fails++;
      $display("FAIL latency_result: got pass=%b code=%h fails=%0d want 0 01 1", pass[2], rc[2], fc[2]);
    end
    tests++;
    if (lat !== 8) begin fails++; $display("FAIL latency_done_cycle: got %0d want 8", lat); end
  endtask
  task automatic test_zero_len;
    int lat, nv;
    run(4, -1, lat, nv);
    tests++;
    if ({lat == 1, nv == 0, pass[4], rc[4], fc[4]} !== {1'b1, 1'b1, 1'b1, 8'h3E, 7'd0}) begin
      fails++;
      $display("FAIL zero_len: got lat=%0d beats=%0d pass=%b code=%h fails=%0d want 1 0 1 3e 0",
               lat, nv, pass[4], rc[4], fc[4]);
    end
  endtask
  task automatic test_reset_mid_run;
    int lat, nv;
    fill(3, 1'b0);
    start[3] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start[3] = 1'b0;
    end
    tests++;
    if (busy[3] !== 1'b1) begin fails++; $display("FAIL midrun_busy: got %b want 1", busy[3]); end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({addr[3], dv[3], busy[3], done[3], pass[3], rc[3], fc[3]} !== 25'd0) begin
      fails++;
      $display("FAIL async_reset: got %h want 0", {addr[3], dv[3], busy[3], done[3], pass[3], rc[3], fc[3]});
    end
    @(negedge clk);
    rst = 1'b0;
    run(3, 2, lat, nv);
    tests++;
    if ({lat == 7, nv == 4, pass[3], rc[3], fc[3]} !== {1'b1, 1'b1, 1'b1, 8'h3E, 7'd0}) begin
      fails++;
      $display("FAIL restart_after_reset: got lat=%0d beats=%0d pass=%b code=%h fails=%0d want 7 4 1 3e 0",
               lat, nv, pass[3], rc[3], fc[3]);
    end
  endtask
  task automatic test_random;
    int lat, nv, elat, env, ecnt, g;
    logic [7:0] ecode;
    for (int it = 0; it < 18; it++) begin
      g = it % 3;
      fill(g, 1'b1);
      model(g, elat, env, ecode, ecnt);
      run(g, -1, lat, nv);
      tests++;
      if (lat !== elat) begin fails++; $display("FAIL random_latency it %0d: got %0d want %0d", it, lat, elat); end
      tests++;
      if (nv !== env) begin fails++; $display("FAIL random_beats it %0d: got %0d want %0d", it, nv, env); end
      tests++;
      if ({pass[g], rc[g], fc[g]} !== {ecnt == 0, ecode, 7'(ecnt)}) begin
        fails++;
        $display("FAIL random_result it %0d: got pass=%b code=%h fails=%0d want %b %h %0d",
                 it, pass[g], rc[g], fc[g], ecnt == 0, ecode, ecnt);
      end
    end
  endtask
  initial begin
    for (int g = 0; g < NI; g++) start[g] = 1'b0;
    for (int g = 0; g < NI; g++) fill(g, 1'b0);
    test_reset;
    test_clean;
    test_stop_on_fail;
    test_continue;
    test_unasserted;
    test_latency;
    test_zero_len;
    test_reset_mid_run;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end
endmodule

// File: doc/esfa_test_sequencer.md
Name: esfa_test_sequencer

Overview:
- Parametrised on-chip self-test sequencer for the ESFA design.
- Streams a program of test instructions from a block ROM into the design under test (DUT), one instruction per cycle, pipelined across ROM and DUT latency.
- Checks each asserted instruction's result and reports a UART-ready result code: pass code, or index of the offending instruction.
- Adds start/done handshake, configurable program length and latencies, and a continue-on-fail mode with error counting.

Parameters:
- ADDR_W, 6: ROM address width. Must be ≤ 8.
- NUM_INSTR, 1: number of instructions in the program. Must be ≤ 2**ADDR_W; checked at elaboration.
- ROM_LAT, 1: cycles from rom_addr to valid rom_data (≥ 1).
- DUT_LAT, 1: cycles from dut_valid to valid dut_result_* (≥ 1).
- PASS_CODE, 8'h3E: result_code value reported on a full pass.
- STOP_ON_FAIL, 1: 1 = halt at first mismatch; 0 = run to end and count mismatches.

Ports:
- clk  in  1: clock, all logic on rising edge.
- rst  in  1: asynchronous, active-high reset.
- start  in  1: pulse that begins a run; ignored while busy.
- rom_addr  out  ADDR_W: instruction address.
- rom_data  in  56: instruction word.
- dut_valid  out  1: instruction fields below are valid this cycle.
- dut_will_write  out  1: rom_data[0].
- dut_new_index  out  8: rom_data[15:8].
- dut_new_value  out  8: rom_data[23:16].
- dut_metadata  out  8: rom_data[31:24]; also the expected value.
- dut_is_metadata  out  1: rom_data[32]; also the expected bool.
- dut_selector  out  8: rom_data[47:40].
- dut_result_bool  in  1: DUT boolean result.
- dut_result_value  in  8: DUT value result.
- busy  out  1: run in progress.
- done  out  1: run finished; level, held until the next accepted start.
- pass  out  1: valid when done; 1 = no mismatches.
- result_code  out  8: PASS_CODE on pass, else the zero-extended first failing index.
- fail_count  out  ADDR_W+1: number of mismatches, saturating.

Behaviour:
- Reset (async assert, sync release): state IDLE; rom_addr=0, dut_valid=0, busy=0, done=0, pass=0, result_code=0, fail_count=0; all pipeline valids cleared.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE or DONE + start: go to RUN. busy=1, done=0, pass=0, fail_count=0, issue index 0.
  - RUN: issue one address per cycle, 0..NUM_INSTR-1. After the last issue, go to DRAIN.
  - DRAIN: wait until every in-flight instruction has retired, then go to DONE.
  - DONE: busy=0, done=1. pass and result_code are final.
- Pipeline timing:
  - Address issued at cycle t.
  - rom_data is valid at t+ROM_LAT. The word is registered and presented on dut_* with dut_valid=1 at t+ROM_LAT+1.
  - The result is compared at t+ROM_LAT+1+DUT_LAT.
  - Expected bool, expected value, assert bit (rom_data[48]) and index travel alongside in a DUT_LAT-deep delay line.
- Check: an instruction mismatches when assert=1 and (dut_result_bool ≠ expected bool, or dut_result_value ≠ expected value). Non-asserted instructions always retire clean.
- STOP_ON_FAIL=1, on the first mismatch:
  - Stop issuing and squash all younger in-flight instructions (their valids are cleared; no checks).
  - result_code = index, pass=0, fail_count=1. Enter DONE on the next cycle.
- STOP_ON_FAIL=0:
  - Run completes in full. fail_count increments per mismatch and saturates at all-ones.
  - result_code latches the first failing index only; later failures do not overwrite it.
- Pass: pass=1 and result_code=PASS_CODE on entering DONE with no mismatches.
- NUM_INSTR=0: start goes directly to DONE on the next cycle with a pass.
- Latency for a clean run of N instructions: start to done = N+ROM_LAT+DUT_LAT+1 cycles.
- start while busy: ignored, no effect on state.
- Reset mid-run: immediate abort to reset values. done is never raised for the aborted run.
- rom_addr never exceeds NUM_INSTR-1. No wrap-around occurs.

Decomposition:
- Package esfa_test_pkg holds:
  - field offset/width constants for the 56-bit instruction word;
  - PASS_CODE default;
  - state encoding.
- One sub-module: esfa_pipe_delay, a parametrised WIDTH×DEPTH register delay line with per-stage valid and synchronous flush. It is used for both the ROM-side stage and the expected-result delay.

Test Plan:
- NUM_INSTR=4, all asserted, DUT model matches: start → done=1 after 4+1+1+1=7 cycles, pass=1, result_code=8'h3E, fail_count=0.
- STOP_ON_FAIL=1, NUM_INSTR=8, mismatch on index 5 → result_code=8'h05, pass=0, fail_count=1. DUT sees no dut_valid for index 7 after the squash; no check occurs for index 6.
- STOP_ON_FAIL=0, NUM_INSTR=8, mismatches at indices 2 and 6 → result_code=8'h02, fail_count=2, done after the full run.
- Index 3 has assert=0 and a wrong result; all others match → pass=1, result_code=8'h3E.
- ROM_LAT=2, DUT_LAT=3, NUM_INSTR=2, mismatch on index 1 → result_code=8'h01. Comparison lands exactly on cycle t+6 for t = issue cycle of index 1.
- rst asserted mid-RUN, then start → all outputs reset asynchronously; the new run starts from index 0 and passes normally. A second start pulsed while busy has no effect.
